// File: rtl/hex_port_display.sv
// hex_port_display
//   Output peripheral between the CPU port_out word and the board's
//   seven-segment displays and LEDs. Captures a data word and a control word
//   on a write strobe, hex-decodes one nibble per digit, applies enable,
//   leading-zero blanking and blink, and drives the digits either statically
//   or time-multiplexed over a shared segment bus.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (assert async, release synchronised)
//   data_in  in   value to display
//   ctrl_in  in   [0] enable, [1] leading-zero blank, [2] blink
//   data_we  in   capture data_in/ctrl_in on this edge
//   seg_out  out  digit k segments at [7k+6:7k], bit order g..a
//   dig_sel  out  digit strobes (all active in static mode, one-hot in multiplex mode)
//   led_out  out  captured data[LED_WIDTH-1:0], active-high

module hex_port_display #(
    parameter int WIDTH_REG  = 32,
    parameter int DIGITS     = 6,
    parameter int LED_WIDTH  = 10,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_DIV   = 50000,
    parameter int MULTIPLEX  = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH_REG-1:0]   data_in,
    input  logic [2:0]             ctrl_in,
    input  logic                   data_we,
    output logic [DIGITS*7-1:0]    seg_out,
    output logic [DIGITS-1:0]      dig_sel,
    output logic [LED_WIDTH-1:0]   led_out
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [6:0]        SEG_INV = {7{ACTIVE_LOW != 0}};
    localparam logic [6:0]        SEG_OFF = SEG_INV;
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{ACTIVE_LOW != 0}};

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [1:0]             sync_q, sync_d;
    logic                   rst_int_n;
    logic [WIDTH_REG-1:0]   data_q, data_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                   phase_on_q, phase_on_d;
    logic [SCAN_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGITS*7-1:0]    seg_q, seg_d;
    logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;
    logic [LED_WIDTH-1:0]   led_q, led_d;

    logic [6:0]             digit_seg [DIGITS];
    logic [DIGITS-1:0]      sel_onehot;
    logic                   zero_run;
    logic                   blink_wrap;
    logic                   scan_wrap;
    logic                   unused_data;

    // Data bits above the displayed nibbles and LEDs are held but never shown.
    assign unused_data = ^data_q;

    // Reset synchroniser: assertion is immediate, release lands two edges later.
    assign sync_d    = {sync_q[0], 1'b1};
    assign rst_int_n = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    always_comb begin
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_on_d  = phase_on_q;
        scan_cnt_d  = '0;
        idx_d       = '0;
        seg_d       = {DIGITS{SEG_OFF}};
        dig_sel_d   = ~SEL_OFF;
        led_d       = data_q[LED_WIDTH-1:0];
        sel_onehot  = '0;
        zero_run    = 1'b1;
        blink_wrap  = (blink_cnt_q == BLINK_LAST);
        scan_wrap   = (scan_cnt_q == SCAN_LAST);

        if (data_we) begin
            data_d = data_in;
            ctrl_d = ctrl_in;
        end

        if (blink_wrap) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
        end

        // Walk from the top digit down so zero_run tells whether every
        // nibble from k upward is zero; digit 0 is always shown.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (data_q[4*k +: 4] == 4'h0);
            if (!ctrl_q[0] || (ctrl_q[2] && !phase_on_q) ||
                (ctrl_q[1] && zero_run && (k != 0))) begin
                digit_seg[k] = SEG_OFF;
            end else begin
                digit_seg[k] = hex7(data_q[4*k +: 4]) ^ SEG_INV;
            end
        end

        if (MULTIPLEX != 0) begin
            // Segments are chosen from the next index so the strobe and the
            // pattern change together on the same edge.
            scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
            idx_d      = idx_q;
            if (scan_wrap) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            seg_d[6:0]        = digit_seg[idx_d];
            sel_onehot[idx_d] = 1'b1;
            dig_sel_d         = sel_onehot ^ SEL_OFF;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                seg_d[7*k +: 7] = digit_seg[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            data_q      <= '0;
            ctrl_q      <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            seg_q       <= {DIGITS{SEG_OFF}};
            dig_sel_q   <= SEL_OFF;
            led_q       <= '0;
        end else begin
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dig_sel_q   <= dig_sel_d;
            led_q       <= led_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = dig_sel_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_hex_port_display.sv
// tb_hex_port_display
//   Directed bench for hex_port_display. One static instance (blink period 4)
//   and one multiplexed instance (scan slot 3) share clock, reset and the
//   write port. Expected patterns are hand-decoded, low-active constants.

module tb_hex_port_display;

    logic        clk;
    logic        reset_n;
    logic [31:0] data_in;
    logic [2:0]  ctrl_in;
    logic        data_we;

    logic [41:0] seg_s;
    logic [5:0]  sel_s;
    logic [9:0]  led_s;
    logic [41:0] seg_m;
    logic [5:0]  sel_m;
    logic [9:0]  led_m;

    int errors = 0;
    int checks = 0;

    localparam logic [41:0] ALL_OFF = {6{7'h7F}};

    // Low-active patterns of the nibbles of 0x00123456, indexed by digit,
    // and the matching one-hot low-active strobe for each scan position.
    logic [6:0] exp_dig [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [5:0] exp_sel [6] = '{6'b111110, 6'b111101, 6'b111011,
                                6'b110111, 6'b101111, 6'b011111};

    hex_port_display #(
        .WIDTH_REG(32), .DIGITS(6), .LED_WIDTH(10),
        .BLINK_DIV(4), .SCAN_DIV(3), .MULTIPLEX(0), .ACTIVE_LOW(1)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .ctrl_in(ctrl_in),
        .data_we(data_we), .seg_out(seg_s), .dig_sel(sel_s), .led_out(led_s)
    );

    hex_port_display #(
        .WIDTH_REG(32), .DIGITS(6), .LED_WIDTH(10),
        .BLINK_DIV(4), .SCAN_DIV(3), .MULTIPLEX(1), .ACTIVE_LOW(1)
    ) dut_m (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .ctrl_in(ctrl_in),
        .data_we(data_we), .seg_out(seg_m), .dig_sel(sel_m), .led_out(led_m)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the write port.
    task automatic applyStimulus(input logic we, input logic [31:0] data,
                                 input logic [2:0] ctrl);
        data_we = we;
        data_in = data;
        ctrl_in = ctrl;
    endtask

    // One comparison point: count it, and count and report it on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulse reset for three edges, release, and return after the two
    // synchroniser edges so the next edge is the first live one.
    task automatic resetAndRelease();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    // Directed sequence: reset, static decode/blanking, blink, multiplex scan
    // and reset in the middle of a scan.
    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 3'b000);
        repeat (3) step();

        $display("[TB] reset state");
        checkOutput("rst_seg_s", seg_s, ALL_OFF);
        checkOutput("rst_sel_s", sel_s, 6'b111111);
        checkOutput("rst_led_s", led_s, 10'h000);
        checkOutput("rst_seg_m", seg_m, ALL_OFF);
        checkOutput("rst_sel_m", sel_m, 6'b111111);

        reset_n = 1'b1;
        step();
        checkOutput("rel_e1_seg", seg_s, ALL_OFF);
        checkOutput("rel_e1_sel", sel_s, 6'b111111);
        step();
        checkOutput("rel_e2_sel", sel_s, 6'b111111);

        $display("[TB] static decode");
        applyStimulus(1'b1, 32'h0012_3456, 3'b001);
        step();
        applyStimulus(1'b0, 32'h0, 3'b000);
        checkOutput("static_sel_on", sel_s, 6'b000000);
        checkOutput("latency_seg", seg_s, ALL_OFF);
        checkOutput("latency_led", led_s, 10'h000);
        step();
        checkOutput("decode_123456", seg_s,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        checkOutput("led_123456", led_s, 10'h056);

        $display("[TB] back-to-back strobes and leading-zero blank");
        applyStimulus(1'b1, 32'h0000_00FF, 3'b001);
        step();
        applyStimulus(1'b1, 32'h0000_00A5, 3'b011);
        step();
        applyStimulus(1'b0, 32'hDEAD_BEEF, 3'b000);
        step();
        checkOutput("lzb_a5", seg_s,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12});
        checkOutput("led_a5", led_s, 10'h0A5);
        repeat (5) step();
        checkOutput("hold_a5", seg_s,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12});

        applyStimulus(1'b1, 32'h0, 3'b011);
        step();
        applyStimulus(1'b0, 32'h0, 3'b000);
        step();
        checkOutput("lzb_zero", seg_s,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        applyStimulus(1'b1, 32'h0001_0203, 3'b011);
        step();
        applyStimulus(1'b0, 32'h0, 3'b000);
        step();
        checkOutput("lzb_inner_zero", seg_s,
                    {7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30});

        applyStimulus(1'b1, 32'h0000_0123, 3'b000);
        step();
        applyStimulus(1'b0, 32'h0, 3'b000);
        step();
        checkOutput("disable_seg", seg_s, ALL_OFF);
        checkOutput("disable_led", led_s, 10'h123);

        $display("[TB] blink");
        resetAndRelease();
        applyStimulus(1'b1, 32'h1, 3'b101);
        step();
        applyStimulus(1'b0, 32'h1, 3'b101);
        step();
        checkOutput("blink_on_e4", seg_s[6:0], 7'h79);
        repeat (2) step();
        checkOutput("blink_on_e6", seg_s[6:0], 7'h79);
        step();
        checkOutput("blink_off_e7", seg_s[6:0], 7'h7F);
        repeat (3) step();
        checkOutput("blink_off_e10", seg_s[6:0], 7'h7F);
        step();
        checkOutput("blink_on_e11", seg_s[6:0], 7'h79);
        repeat (6) step();
        applyStimulus(1'b1, 32'h2, 3'b101);
        step();
        applyStimulus(1'b0, 32'h2, 3'b101);
        checkOutput("blink_off_e18", seg_s[6:0], 7'h7F);
        step();
        checkOutput("blink_we_toggle", seg_s[6:0], 7'h24);
        checkOutput("blink_led", led_s, 10'h002);

        $display("[TB] multiplex scan");
        resetAndRelease();
        applyStimulus(1'b1, 32'h0012_3456, 3'b001);
        step();
        applyStimulus(1'b0, 32'h0, 3'b000);
        checkOutput("mux_first_sel", sel_m, 6'b111110);
        step();
        checkOutput("mux_d0_sel", sel_m, 6'b111110);
        checkOutput("mux_d0_seg", seg_m, {{5{7'h7F}}, 7'h02});
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) repeat (3) step();
            checkOutput("mux_scan_sel", sel_m, exp_sel[k % 6]);
            checkOutput("mux_scan_seg", seg_m, {{5{7'h7F}}, exp_dig[k % 6]});
        end
        repeat (9) step();
        checkOutput("mux_d3_sel", sel_m, 6'b110111);
        checkOutput("mux_d3_seg", seg_m[6:0], 7'h30);

        $display("[TB] reset mid-scan");
        step();
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_seg", seg_m, ALL_OFF);
        checkOutput("midrst_sel", sel_m, 6'b111111);
        checkOutput("midrst_led", led_m, 10'h000);
        #1;
        reset_n = 1'b1;
        repeat (2) step();
        checkOutput("midrst_hold_sel", sel_m, 6'b111111);
        step();
        checkOutput("midrst_resume_sel", sel_m, 6'b111110);
        checkOutput("midrst_resume_seg", seg_m, ALL_OFF);
        checkOutput("midrst_resume_led", led_m, 10'h000);
        repeat (2) step();
        checkOutput("midrst_next_sel", sel_m, 6'b111101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
